rr_burst_arbiter: RTL

- Shares one downstream sink (a sub-block with a valid+data input and a registered stage) among N upstream requesters.
- Each requester presents a valid/data/last stream.
- The arbiter grants round-robin, holds a grant for a whole burst (until last), and force-releases after MAX_BURST beats.
- Grant and output are registered, giving one beat per cycle at full throughput with 1-cycle latency.

---
 rtl/rr_burst_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: N valid/data/last streams share one registered sink.
// A grant is held until last, or force-released after MAX_BURST beats.
module rr_burst_arbiter #(
  parameter  int N         = 4,
  parameter  int DW        = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic [1:0]      clock_reset,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [IDW-1:0]  out_id,
  input  logic            out_ready,
  output logic            overrun
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  logic           w_clk;
  logic           w_rst;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_owner;
  logic [7:0]     r_beat_cnt;

  logic           r_out_valid;
  logic [DW-1:0]  r_out_data;
  logic           r_out_last;
  logic [IDW-1:0] r_out_id;
  logic           r_overrun;

  logic           w_sel_vld;
  logic [IDW-1:0] w_sel;
  logic           w_load_en;
  logic           w_go;
  logic           w_xfer;
  logic [DW-1:0]  w_sel_data;
  logic           w_sel_last;
  logic [8:0]     w_cnt_inc;
  logic           w_forced;
  logic           w_release;

  assign w_clk = clock_reset[0];
  assign w_rst = clock_reset[1];

  // State register
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer && !w_release) begin
          w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_xfer && w_release) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Selection: owner while locked, else rotate from the slot after ptr
  always_comb begin
    logic [IDW-1:0] v_idx;
    v_idx     = '0;
    w_sel     = '0;
    w_sel_vld = 1'b0;
    unique case (r_state)
      S_LOCKED: begin
        w_sel     = r_owner;
        w_sel_vld = 1'b1;
      end
      default: begin
        for (int i = 1; i <= N; i++) begin
          v_idx = IDW'((int'(r_ptr) + i) % N);
          if (!w_sel_vld && req_valid[v_idx]) begin
            w_sel     = v_idx;
            w_sel_vld = 1'b1;
          end
        end
      end
    endcase
  end

  assign w_load_en = !r_out_valid || out_ready;
  assign w_go      = w_load_en && !w_rst && w_sel_vld;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (w_go && (w_sel == IDW'(k))) begin
        req_ready[k] = 1'b1;
      end
    end
  end

  assign w_xfer     = w_go && req_valid[w_sel];
  assign w_sel_data = req_data[int'(w_sel)*DW +: DW];
  assign w_sel_last = req_last[w_sel];
  assign w_cnt_inc  = {1'b0, r_beat_cnt} + 9'd1;
  assign w_forced   = (w_cnt_inc == 9'(MAX_BURST)) && !w_sel_last;
  assign w_release  = w_sel_last || w_forced;

  // Grant bookkeeping; ptr takes the just-served id so it drops to lowest priority
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_ptr      <= IDW'(N - 1);
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else if (w_xfer) begin
      if (w_release) begin
        r_ptr      <= w_sel;
        r_beat_cnt <= '0;
      end else begin
        r_owner    <= w_sel;
        r_beat_cnt <= w_cnt_inc[7:0];
      end
    end
  end

  // Output register
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_xfer && w_forced;
      if (w_load_en) begin
        r_out_valid <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_sel_data;
          r_out_last <= w_release;
          r_out_id   <= w_sel;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_id    = r_out_id;
  assign overrun   = r_overrun;

endmodule
